// File: rtl/cpu_0_ocimem_engine.sv
// Debug-memory engine between the JTAG debug module and a single-port debug RAM.
// JTAG host reads/writes via MonAReg/MonDReg; the CPU shares the RAM through an Avalon-style slave.
module cpu_0_ocimem_engine #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic [ADDR_W-1:0] address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic [3:0]        byteenable,
   output logic [31:0]       readdata,
   output logic              waitrequest,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error
);

   typedef enum logic [2:0] {S_IDLE, S_JRD, S_JRD_WAIT, S_JWR, S_CRD} state_e;

   localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] mon_a_q, mon_a_d;
   logic [31:0]       mon_d_q, mon_d_d;
   logic              ready_q, ready_d;
   logic              error_q, error_d;
   logic              op_wr_q, op_wr_d;
   logic [31:0]       readdata_q, readdata_d;
   logic              cpu_ok_q, cpu_ok_d;

   logic [31:0]       mem [DEPTH];
   logic [31:0]       ram_rdata_q;
   logic [ADDR_W-1:0] ram_addr;
   logic [3:0]        ram_we;
   logic [31:0]       ram_wdata;

   logic [ADDR_W-1:0] jdo_addr;
   logic              jdo_addr_ok, mon_a_ok, cpu_addr_ok;
   logic [ADDR_W-1:0] mon_a_next;
   logic [31:0]       crd_data;
   logic              unused_ok;

   assign jdo_addr    = jdo[18 +: ADDR_W];
   assign jdo_addr_ok = {1'b0, jdo_addr} < DEPTH_W;
   assign mon_a_ok    = {1'b0, mon_a_q} < DEPTH_W;
   assign cpu_addr_ok = {1'b0, address} < DEPTH_W;
   assign mon_a_next  = (mon_a_q == LAST_ADDR) ? '0 : mon_a_q + 1'b1;
   assign crd_data    = cpu_ok_q ? ram_rdata_q : '0;
   assign unused_ok   = ^{take_no_action_ocimem_a, jdo[37:35], jdo[2:0]};

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      state_d     = state_q;
      mon_a_d     = mon_a_q;
      mon_d_d     = mon_d_q;
      ready_d     = ready_q;
      error_d     = error_q;
      op_wr_d     = op_wr_q;
      readdata_d  = readdata_q;
      cpu_ok_d    = cpu_ok_q;
      ram_addr    = mon_a_q;
      ram_we      = '0;
      ram_wdata   = mon_d_q;
      waitrequest = 1'b0;

      if (take_action_ocimem_a || take_action_ocimem_b) begin
         if (!ready_q) begin
            error_d = 1'b1;
         end else if (take_action_ocimem_a) begin
            mon_a_d = jdo_addr;
            error_d = !jdo_addr_ok;
            if (jdo_addr_ok && jdo[17]) begin
               ready_d = 1'b0;
               op_wr_d = 1'b0;
            end
         end else begin
            mon_d_d = jdo[34:3];
            error_d = error_q | !mon_a_ok;
            if (mon_a_ok) begin
               ready_d = 1'b0;
               op_wr_d = 1'b1;
            end
         end
      end

      case (state_q)
         S_IDLE: begin
            ram_addr = address;
            // The CPU always wins; a pending JTAG op waits for a free IDLE cycle.
            if (read) begin
               waitrequest = 1'b1;
               cpu_ok_d    = cpu_addr_ok;
               state_d     = S_CRD;
            end else if (write) begin
               ram_wdata = writedata;
               if (cpu_addr_ok) ram_we = byteenable;
            end else if (!ready_q) begin
               state_d = op_wr_q ? S_JWR : S_JRD;
            end
         end
         S_JRD: begin
            waitrequest = read | write;
            state_d     = S_JRD_WAIT;
         end
         S_JRD_WAIT: begin
            waitrequest = read | write;
            mon_d_d     = ram_rdata_q;
            mon_a_d     = mon_a_next;
            ready_d     = 1'b1;
            state_d     = S_IDLE;
         end
         S_JWR: begin
            waitrequest = read | write;
            ram_we      = 4'hF;
            mon_a_d     = mon_a_next;
            ready_d     = 1'b1;
            state_d     = S_IDLE;
         end
         S_CRD: begin
            readdata_d = crd_data;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         mon_a_q    <= '0;
         mon_d_q    <= '0;
         ready_q    <= 1'b1;
         error_q    <= 1'b0;
         op_wr_q    <= 1'b0;
         readdata_q <= '0;
         cpu_ok_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         mon_a_q    <= mon_a_d;
         mon_d_q    <= mon_d_d;
         ready_q    <= ready_d;
         error_q    <= error_d;
         op_wr_q    <= op_wr_d;
         readdata_q <= readdata_d;
         cpu_ok_q   <= cpu_ok_d;
      end
   end

   // NOTE: the RAM array and its read register have no reset so they map onto block RAM.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      ram_rdata_q <= mem[ram_addr];
   end

   // Read data is presented during CRD, when waitrequest is low, and then held.
   assign readdata      = (state_q == S_CRD) ? crd_data : readdata_q;
   assign MonDReg       = mon_d_q;
   assign monitor_ready = ready_q;
   assign monitor_error = error_q;

endmodule
